// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit.
// Keeps the PC, issues one instruction-memory read at a time and hands the
// returned word to decode through a registered output stage. A stalled
// decode parks the returned word in a one-entry hold buffer. A redirect from
// execute overrides everything except reset. Any response to a request that
// was made before the redirect is thrown away.
//
// Handshake: mem_req_o is a one-cycle request with no back-pressure. The
// memory answers each request exactly once with a one-cycle mem_rvalid_i, no
// earlier than the following cycle. Toward decode, inst_valid_o marks a real
// instruction and stall_i acts as an inverted ready: the output registers move
// only when stall_i=0, or on a redirect.
module ifu_fetch #(
  parameter logic [31:0] INI_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_discard;
  logic [31:0] r_hold;
  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        r_inst_valid;
  logic        w_req;

  // A request goes out in FETCH unless a redirect is arriving this cycle.
  // Reset suppresses it because the state register may still be stale.
  assign w_req = rst && (r_state == S_FETCH) && !jump_flag_i;

  assign mem_req_o    = w_req;
  assign mem_addr_o   = r_pc;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;
  assign dbg_state_o  = r_state;

  // Fetch FSM, PC, discard flag, hold buffer and decode-facing output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_pc         <= INI_ADDR;
      r_discard    <= 1'b0;
      r_hold       <= 32'h0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= INI_ADDR;
      r_inst_valid <= 1'b0;
    end else if (jump_flag_i) begin
      // A redirect flushes the output stage and the hold buffer and reloads the PC.
      r_pc         <= {jump_addr_i[31:2], 2'b00};
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
      r_hold       <= 32'h0;
      if (r_state == S_WAIT && !mem_rvalid_i) begin
        // The in-flight response still has to drain, so it is marked stale.
        r_discard <= 1'b1;
        r_state   <= S_WAIT;
      end else begin
        // A same-cycle response is consumed here and dropped.
        r_discard <= 1'b0;
        r_state   <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_req) begin
            r_state <= S_WAIT;
          end
          if (!stall_i) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i && r_discard) begin
            r_discard <= 1'b0;
            r_state   <= S_FETCH;
            if (!stall_i) begin
              r_inst       <= NOP_INST;
              r_inst_valid <= 1'b0;
            end
          end else if (mem_rvalid_i && !stall_i) begin
            r_inst       <= mem_rdata_i;
            r_inst_addr  <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_state      <= S_FETCH;
          end else if (mem_rvalid_i) begin
            r_hold  <= mem_rdata_i;
            r_state <= S_HOLD;
          end else if (!stall_i) begin
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            r_inst       <= r_hold;
            r_inst_addr  <= r_pc;
            r_inst_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
            r_state      <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed scenarios followed by randomized traffic. A
// transaction-level reference model predicts the fetch unit's outputs. A
// behavioural memory answers each request after a random latency.
module tb_ifu_fetch;

  localparam logic [31:0] INI = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset block ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  ifu_fetch #(.INI_ADDR(INI), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .stall_i     (stall_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .inst_valid_o(inst_valid_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];   // addresses the bench expects decode to receive, in order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural memory ----------------
  int          fixed_lat = 1;   // 0 selects a random latency of 1..3 cycles
  bit          spurious_en = 0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0010_8F93;
    if (a == 32'h0000_0040) return 32'hFE20_D063;
    return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc = INI;
  bit          m_busy = 0;    // a read is in flight
  bit          m_stale = 0;   // that read belongs to an abandoned path
  bit          m_have = 0;    // a returned word is parked waiting for decode
  logic [31:0] m_hold = '0;
  logic [31:0] e_inst = NOP;
  logic [31:0] e_iaddr = INI;
  logic        e_ival = 1'b0;
  bit          m_known = 0;
  logic        last_req;
  logic [31:0] last_addr;

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic s_rst, input logic s_jmp, input logic [31:0] s_jaddr,
                      input logic s_stall);
    logic        e_req;
    logic        got;
    logic        avail;
    logic [31:0] word;
    logic [31:0] pc0;
    @(negedge clk);
    rst          = s_rst;
    jump_flag_i  = s_jmp;
    jump_addr_i  = s_jaddr;
    stall_i      = s_stall;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (!s_rst) begin
      mem_pend = 0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_word(mem_paddr);
        mem_pend     = 0;
      end
    end else if (spurious_en && $urandom_range(0, 15) == 0) begin
      mem_rvalid_i = 1'b1;
    end
    #1;
    e_req     = s_rst && !m_busy && !m_have && !s_jmp;
    last_req  = mem_req_o;
    last_addr = mem_addr_o;
    chk("mem_req", {31'b0, mem_req_o}, {31'b0, e_req});
    if (e_req) chk("mem_addr", mem_addr_o, m_pc);
    if (m_known) begin
      chk("inst", inst_o, e_inst);
      chk("inst_addr", inst_addr_o, e_iaddr);
      chk("inst_valid", {31'b0, inst_valid_o}, {31'b0, e_ival});
    end
    pc0 = m_pc;
    if (!s_rst) begin
      m_pc = INI; m_busy = 0; m_stale = 0; m_have = 0;
      e_inst = NOP; e_iaddr = INI; e_ival = 1'b0; m_known = 1;
      exp_q.delete();
    end else if (s_jmp) begin
      if (m_busy && !mem_rvalid_i) m_stale = 1;
      else begin m_busy = 0; m_stale = 0; end
      m_pc = {s_jaddr[31:2], 2'b00};
      m_have = 0; e_inst = NOP; e_ival = 1'b0;
    end else begin
      got   = m_busy && mem_rvalid_i;
      avail = m_have || (got && !m_stale);
      word  = m_have ? m_hold : mem_rdata_i;
      if (got) begin m_busy = 0; m_stale = 0; end
      if (e_req) m_busy = 1;
      if (!s_stall) begin
        if (avail) begin
          e_inst = word; e_iaddr = m_pc; e_ival = 1'b1;
          m_pc = m_pc + 32'd4; m_have = 0;
        end else begin
          e_inst = NOP; e_ival = 1'b0;
        end
      end else if (avail && !m_have) begin
        m_have = 1; m_hold = mem_rdata_i;
      end
    end
    if (e_req) begin
      mem_pend  = 1;
      mem_paddr = pc0;
      mem_cnt   = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 3);
      exp_q.push_back(pc0);
    end
    @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0; stall_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    // Reset release with 1-cycle memory
    fixed_lat = 1;
    repeat (3) step(0, 0, 0, 0);
    #1;
    chk("rst_inst", inst_o, NOP);
    chk("rst_inst_addr", inst_addr_o, INI);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    step(1, 0, 0, 0);
    chk("r33_req", {31'b0, last_req}, 32'd1);
    chk("r33_addr0", last_addr, 32'h0);
    step(1, 0, 0, 0);
    #1;
    chk("r33_inst", inst_o, 32'h0010_8F93);
    chk("r33_iaddr", inst_addr_o, 32'h0);
    chk("r33_valid", {31'b0, inst_valid_o}, 32'd1);
    step(1, 0, 0, 0);
    chk("r33_next_addr", last_addr, 32'h4);

    // Stall while the response arrives, held for 3 cycles
    step(1, 0, 0, 0);                  // response for addr 4 delivered
    step(1, 1, 32'h0000_0040, 0);      // redirect to 0x40 from FETCH
    step(1, 0, 0, 0);                  // request 0x40
    step(1, 0, 0, 1);                  // rvalid under stall -> parked
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("r34_no_req", {31'b0, last_req}, 32'd0);
    step(1, 0, 0, 0);                  // release
    #1;
    chk("r34_inst", inst_o, 32'hFE20_D063);
    chk("r34_iaddr", inst_addr_o, 32'h40);
    chk("r34_valid", {31'b0, inst_valid_o}, 32'd1);
    step(1, 0, 0, 0);
    chk("r34_next_addr", last_addr, 32'h44);

    // Redirect during WAIT, stale response arrives 2 cycles later
    step(1, 0, 0, 0);                  // deliver 0x44
    fixed_lat = 3;
    step(1, 0, 0, 0);                  // request 0x48, latency 3
    step(1, 1, 32'h0000_0103, 0);      // redirect while waiting
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);                  // stale response dropped
    #1;
    chk("r35_valid", {31'b0, inst_valid_o}, 32'd0);
    fixed_lat = 1;
    step(1, 0, 0, 0);
    chk("r35_next_addr", last_addr, 32'h0000_0100);

    // Redirect with stall while a valid instruction is presented
    step(1, 0, 0, 0);                  // response 0x100 delivered
    step(1, 0, 0, 1);                  // valid held under stall, request 0x104
    step(1, 1, 32'h0000_0200, 1);      // redirect + stall, response dropped
    #1;
    chk("r36_inst", inst_o, NOP);
    chk("r36_valid", {31'b0, inst_valid_o}, 32'd0);
    step(1, 0, 0, 0);
    chk("r36_pc", last_addr, 32'h0000_0200);

    // PC wrap
    step(1, 0, 0, 0);
    step(1, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #1;
    chk("r37_iaddr", inst_addr_o, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("r37_wrap_addr", last_addr, 32'h0000_0000);

    // Reset while a word is parked
    step(1, 0, 0, 1);                  // response under stall -> parked
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);                  // one reset cycle
    #1;
    chk("r38_inst", inst_o, NOP);
    chk("r38_iaddr", inst_addr_o, INI);
    chk("r38_valid", {31'b0, inst_valid_o}, 32'd0);
    step(1, 0, 0, 0);
    chk("r38_next_addr", last_addr, INI);

    // Randomized traffic
    fixed_lat   = 0;
    spurious_en = 1;
    for (int i = 0; i < 4000; i++) begin
      logic        r_rst;
      logic        r_jmp;
      logic [31:0] r_ja;
      logic        r_stl;
      r_rst = ($urandom_range(0, 249) != 0);
      r_jmp = ($urandom_range(0, 19) == 0);
      r_ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      r_stl = ($urandom_range(0, 9) < 3);
      step(r_rst, r_jmp, r_ja, r_stl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
